// File: rtl/bnn_seq_pkg.sv
// Shared types and defaults for the BNN frame sequencer.
package bnn_seq_pkg;

    localparam int unsigned DefaultRows    = 16;
    localparam int unsigned DefaultCols    = 16;
    localparam int unsigned DefaultClasses = 4;
    localparam int unsigned DefaultScoreW  = 7;

    typedef enum logic [1:0] {
        StLoad,
        StSettle,
        StArgmax,
        StOutput
    } state_e;

    typedef logic [DefaultCols-1:0]   row_t;
    typedef row_t [DefaultRows-1:0]   frame_t;
    typedef logic [DefaultScoreW-1:0] score_t;
    typedef score_t [DefaultClasses-1:0] scores_t;

    // Counter width that stays legal for a count of one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_frame_sequencer_if.sv
// Row input stream and result output handshake of the frame sequencer.
interface bnn_frame_sequencer_if
    import bnn_seq_pkg::*;
#(
    parameter int unsigned COLS      = DefaultCols,
    parameter int unsigned N_CLASSES = DefaultClasses,
    parameter int unsigned SCORE_W   = DefaultScoreW
) ();

    localparam int unsigned IdxW = cnt_width(N_CLASSES);

    logic                row_valid;
    logic                row_ready;
    logic [COLS-1:0]     row_data;
    logic                res_valid;
    logic                res_ready;
    logic [IdxW-1:0]     res_class;
    logic [SCORE_W-1:0]  res_score;

    // Environment side: supplies rows, consumes results.
    modport master (
        output row_valid, row_data, res_ready,
        input  row_ready, res_valid, res_class, res_score
    );

    // Sequencer side.
    modport slave (
        input  row_valid, row_data, res_ready,
        output row_ready, res_valid, res_class, res_score
    );

endinterface

// File: rtl/bnn_argmax_seq.sv
// Captures a score vector and walks it one class per cycle to find the maximum.
module bnn_argmax_seq
    import bnn_seq_pkg::*;
#(
    parameter int unsigned N_CLASSES = DefaultClasses,
    parameter int unsigned SCORE_W   = DefaultScoreW,
    localparam int unsigned IdxW     = cnt_width(N_CLASSES)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [N_CLASSES-1:0][SCORE_W-1:0] scores_i,
    output logic                              done_o,
    output logic [IdxW-1:0]                   res_idx_o,
    output logic [SCORE_W-1:0]                res_score_o
);

    logic [N_CLASSES-1:0][SCORE_W-1:0] score_q;
    logic [IdxW-1:0]    idx_q;
    logic [IdxW-1:0]    best_idx_q, best_idx_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               run_q;
    logic               last;
    logic               take;

    // Strict-greater compare keeps the lowest index on ties.
    always_comb begin
        take       = score_q[idx_q] > best_q;
        best_d     = take ? score_q[idx_q] : best_q;
        best_idx_d = take ? idx_q : best_idx_q;
        last       = (idx_q == IdxW'(N_CLASSES - 1));
        done_o     = run_q & last;
    end

    // The final result is exposed alongside done_o so no extra cycle is spent.
    assign res_idx_o   = best_idx_d;
    assign res_score_o = best_d;

    // Score capture and per-class scan.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            score_q    <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            run_q      <= 1'b0;
        end else if (start_i) begin
            score_q    <= scores_i;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            run_q      <= 1'b1;
        end else if (run_q) begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            if (last) begin
                run_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IdxW'(1);
            end
        end
    end

endmodule

// File: rtl/bnn_frame_sequencer.sv
// Assembles an image frame for bnn_top, waits for it to settle, then reports the argmax.
module bnn_frame_sequencer
    import bnn_seq_pkg::*;
#(
    parameter int unsigned ROWS          = DefaultRows,
    parameter int unsigned COLS          = DefaultCols,
    parameter int unsigned N_CLASSES     = DefaultClasses,
    parameter int unsigned SCORE_W       = DefaultScoreW,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    bnn_frame_sequencer_if.slave              bus,
    output logic [ROWS-1:0][COLS-1:0]         frame_o,
    input  logic [N_CLASSES-1:0][SCORE_W-1:0] scores_i,
    output logic                              busy_o
);

    localparam int unsigned RowW    = cnt_width(ROWS);
    localparam int unsigned SettleW = cnt_width(SETTLE_CYCLES);
    localparam int unsigned IdxW    = cnt_width(N_CLASSES);

    state_e                    state_q;
    logic [RowW-1:0]           row_cnt_q;
    logic [SettleW-1:0]        settle_cnt_q;
    logic [ROWS-1:0][COLS-1:0] frame_q;
    logic                      row_ready_q;
    logic                      res_valid_q;
    logic [IdxW-1:0]           res_class_q;
    logic [SCORE_W-1:0]        res_score_q;
    logic                      busy_q;

    logic                      settle_done;
    logic                      am_done;
    logic [IdxW-1:0]           am_idx;
    logic [SCORE_W-1:0]        am_score;

    // Last settle cycle doubles as the score capture strobe.
    assign settle_done = (state_q == StSettle) &&
                         (settle_cnt_q == SettleW'(SETTLE_CYCLES - 1));

    bnn_argmax_seq #(
        .N_CLASSES (N_CLASSES),
        .SCORE_W   (SCORE_W)
    ) u_argmax (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (settle_done),
        .scores_i    (scores_i),
        .done_o      (am_done),
        .res_idx_o   (am_idx),
        .res_score_o (am_score)
    );

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StLoad;
            row_cnt_q    <= '0;
            settle_cnt_q <= '0;
            frame_q      <= '0;
            row_ready_q  <= 1'b1;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_score_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (bus.row_valid && row_ready_q) begin
                        frame_q[row_cnt_q] <= bus.row_data;
                        busy_q             <= 1'b1;
                        if (row_cnt_q == RowW'(ROWS - 1)) begin
                            row_cnt_q    <= '0;
                            settle_cnt_q <= '0;
                            row_ready_q  <= 1'b0;
                            state_q      <= StSettle;
                        end else begin
                            row_cnt_q <= row_cnt_q + RowW'(1);
                        end
                    end
                end
                StSettle: begin
                    if (settle_done) begin
                        state_q <= StArgmax;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SettleW'(1);
                    end
                end
                StArgmax: begin
                    if (am_done) begin
                        res_valid_q <= 1'b1;
                        res_class_q <= am_idx;
                        res_score_q <= am_score;
                        state_q     <= StOutput;
                    end
                end
                StOutput: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        row_ready_q <= 1'b1;
                        state_q     <= StLoad;
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    assign frame_o       = frame_q;
    assign busy_o        = busy_q;
    assign bus.row_ready = row_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_class = res_class_q;
    assign bus.res_score = res_score_q;

endmodule

// File: tb/tb_bnn_frame_sequencer.sv
// Directed bench for bnn_frame_sequencer.
module tb_bnn_frame_sequencer;
    import bnn_seq_pkg::*;

    logic    clk_i;
    logic    rst_ni;
    frame_t  frame;
    scores_t scores;
    logic    busy;

    int n_checks = 0;
    int n_bad    = 0;

    bnn_frame_sequencer_if bus ();

    bnn_frame_sequencer u_dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .bus      (bus),
        .frame_o  (frame),
        .scores_i (scores),
        .busy_o   (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic row_t pat(input int i);
        return row_t'(i * 'h1357) ^ 16'hA5A5;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " frame"}, frame, '0);
        check({tag, " row_ready"}, bus.row_ready, 1'b1);
        check({tag, " res_valid"}, bus.res_valid, 1'b0);
        check({tag, " res_class"}, bus.res_class, '0);
        check({tag, " res_score"}, bus.res_score, '0);
        check({tag, " busy"}, busy, 1'b0);
    endtask

    // Back-to-back row load; returns just after the last accepting edge.
    task automatic load_frame(input frame_t f);
        int guard;
        check("busy before frame", busy, 1'b0);
        for (int r = 0; r < DefaultRows; r++) begin
            bus.row_valid = 1'b1;
            bus.row_data  = f[r];
            guard = 0;
            while (!bus.row_ready && guard < 100) begin
                tick();
                guard++;
            end
            check("row_ready in load", bus.row_ready, 1'b1);
            tick();
            if (r == 0) check("busy after first row", busy, 1'b1);
        end
        bus.row_valid = 1'b0;
        check("row_ready after last", bus.row_ready, 1'b0);
        check("frame", frame, f);
    endtask

    // Counts cycles from the last row handshake to res_valid.
    task automatic wait_result(input logic [1:0] ec, input logic [6:0] es, input bit swap);
        int cnt;
        cnt = 0;
        while (!bus.res_valid && cnt < 40) begin
            tick();
            cnt++;
            if (swap && cnt == 8) scores = {7'd0, 7'd0, 7'd0, 7'd127};
        end
        check("latency", cnt, 12);
        check("res_class", bus.res_class, ec);
        check("res_score", bus.res_score, es);
        check("busy in output", busy, 1'b1);
    endtask

    task automatic take_result(input logic [1:0] ec, input logic [6:0] es);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("res_valid after hs", bus.res_valid, 1'b0);
        check("row_ready after hs", bus.row_ready, 1'b1);
        check("busy after hs", busy, 1'b0);
        check("res_class retained", bus.res_class, ec);
        check("res_score retained", bus.res_score, es);
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs(tag);
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        frame_t f;
        rst_ni        = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.res_ready = 1'b0;
        scores        = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        check_reset_outputs("reset release");
        for (int i = 0; i < 20; i++) tick();
        check_reset_outputs("idle 20");

        // Diagonal frame, tie between classes 1 and 2.
        for (int r = 0; r < DefaultRows; r++) f[r] = row_t'(1) << r;
        scores = {7'd3, 7'd50, 7'd50, 7'd10};
        load_frame(f);
        wait_result(2'd1, 7'd50, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp res_valid", bus.res_valid, 1'b1);
            check("bp res_class", bus.res_class, 2'd1);
            check("bp res_score", bus.res_score, 7'd50);
            check("bp row_ready", bus.row_ready, 1'b0);
        end
        take_result(2'd1, 7'd50);

        // All-zero frame and scores.
        scores = '0;
        load_frame('0);
        wait_result(2'd0, 7'd0, 1'b0);
        take_result(2'd0, 7'd0);

        // Gapped input; scores altered once captured.
        scores = {7'd4, 7'd3, 7'd2, 7'd1};
        for (int i = 0; i <= 30; i++) begin
            bus.row_valid = (i % 2) == 0;
            bus.row_data  = pat(i);
            tick();
            if (i == 29) begin
                check("gap row_ready at 15", bus.row_ready, 1'b1);
                check("gap busy", busy, 1'b1);
            end
        end
        bus.row_valid = 1'b0;
        check("gap row_ready after 16", bus.row_ready, 1'b0);
        for (int r = 0; r < DefaultRows; r++) f[r] = pat(2 * r);
        check("gap frame", frame, f);
        wait_result(2'd3, 7'd4, 1'b1);
        take_result(2'd3, 7'd4);

        // Reset during SETTLE.
        for (int r = 0; r < DefaultRows; r++) f[r] = ~(row_t'(1) << r);
        scores = {7'd100, 7'd100, 7'd9, 7'd5};
        load_frame(f);
        tick();
        tick();
        tick();
        async_reset("rst settle");

        // Full frame after reset, then reset during OUTPUT.
        load_frame(f);
        wait_result(2'd2, 7'd100, 1'b0);
        async_reset("rst output");

        scores = {7'd79, 7'd30, 7'd80, 7'd20};
        load_frame(f);
        wait_result(2'd1, 7'd80, 1'b0);
        take_result(2'd1, 7'd80);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
